// File: rtl/riscv_uart_wrapper.sv
// Touch-bell SoC wrapper: 8N1 UART receiver feeding a program loader into a
// word-wide instruction memory, plus a touch-to-bell GPIO path enabled once loading ends.
module riscv_uart_wrapper #(
  parameter int          CLK_HZ     = 50_000_000,
  parameter int          BIT_RATE   = 9600,
  parameter int          IMEM_DEPTH = 32,
  parameter logic [31:0] END_MARKER = 32'hFFFF_FFFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rxd,
  input  logic       uart_rx_en,
  output logic       uart_rx_break,
  output logic       uart_rx_valid,
  output logic [7:0] uart_rx_data,
  input  logic       input_gpio_pins,
  output logic       output_gpio_pins,
  output logic       write_done
);

  localparam int              CLKS_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int              AW           = $clog2(IMEM_DEPTH);
  localparam logic [15:0]     BIT_LAST     = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0]     HALF_LAST    = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [AW:0]     DEPTH_CNT    = (AW + 1)'(IMEM_DEPTH);

  // S_BREAK holds off re-arming until the line has returned high after a BREAK.
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} rx_state_e;

  rx_state_e   state_q, state_d;
  logic [15:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        rx_break_q, rx_break_d;
  logic        rxd_s1_q, rxd_s2_q;

  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [23:0] word_buf_q, word_buf_d;
  logic [AW:0] word_addr_q, word_addr_d;
  logic        write_done_q, write_done_d;
  logic        imem_we;
  logic [31:0] imem_wdata;
  logic [31:0] imem_q [IMEM_DEPTH];

  logic        gpio_s1_q, gpio_s2_q;
  logic        bell_q, bell_d;

  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q + 16'd1;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_break_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        clk_cnt_d = '0;
        if (uart_rx_en && !rxd_s2_q) begin
          state_d   = S_START;
          bit_cnt_d = '0;
        end
      end
      S_START: begin
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d = '0;
          state_d   = rxd_s2_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          shift_d   = {rxd_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          state_d   = S_IDLE;
          if (rxd_s2_q) begin
            rx_valid_d = 1'b1;
            rx_data_d  = shift_q;
          end else if (shift_q == 8'h00) begin
            rx_break_d = 1'b1;
            state_d    = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        clk_cnt_d = '0;
        if (rxd_s2_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (!uart_rx_en && state_q != S_IDLE) begin
      state_d    = S_IDLE;
      clk_cnt_d  = '0;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      rx_break_d = 1'b0;
    end
  end

  // The fourth byte is never buffered: it goes straight into the top lane of the write data.
  always_comb begin
    byte_cnt_d   = byte_cnt_q;
    word_buf_d   = word_buf_q;
    word_addr_d  = word_addr_q;
    write_done_d = write_done_q;
    imem_we      = 1'b0;
    imem_wdata   = {rx_data_q, word_buf_q};
    if (rx_valid_q && !write_done_q) begin
      byte_cnt_d = byte_cnt_q + 2'd1;
      case (byte_cnt_q)
        2'd0: word_buf_d[7:0]   = rx_data_q;
        2'd1: word_buf_d[15:8]  = rx_data_q;
        2'd2: word_buf_d[23:16] = rx_data_q;
        default: begin
          if (imem_wdata == END_MARKER) begin
            write_done_d = 1'b1;
          end else begin
            imem_we     = 1'b1;
            word_addr_d = word_addr_q + 1'b1;
            if (word_addr_d == DEPTH_CNT) write_done_d = 1'b1;
          end
        end
      endcase
    end
  end

  assign bell_d = write_done_q & gpio_s2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      clk_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_break_q   <= 1'b0;
      rxd_s1_q     <= 1'b1;
      rxd_s2_q     <= 1'b1;
      byte_cnt_q   <= '0;
      word_buf_q   <= '0;
      word_addr_q  <= '0;
      write_done_q <= 1'b0;
      gpio_s1_q    <= 1'b0;
      gpio_s2_q    <= 1'b0;
      bell_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      clk_cnt_q    <= clk_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      rx_break_q   <= rx_break_d;
      rxd_s1_q     <= uart_rxd;
      rxd_s2_q     <= rxd_s1_q;
      byte_cnt_q   <= byte_cnt_d;
      word_buf_q   <= word_buf_d;
      word_addr_q  <= word_addr_d;
      write_done_q <= write_done_d;
      gpio_s1_q    <= input_gpio_pins;
      gpio_s2_q    <= gpio_s1_q;
      bell_q       <= bell_d;
    end
  end

  // Program storage survives rst so the core can be restarted without reloading.
  always_ff @(posedge clk) begin
    if (imem_we) imem_q[word_addr_q[AW-1:0]] <= imem_wdata;
  end

  assign uart_rx_valid    = rx_valid_q;
  assign uart_rx_break    = rx_break_q;
  assign uart_rx_data     = rx_data_q;
  assign write_done       = write_done_q;
  assign output_gpio_pins = bell_q;

endmodule

// File: tb/tb_riscv_uart_wrapper.sv
// Directed bench for riscv_uart_wrapper: UART reception, BREAK, program loading,
// end marker, memory-full stop, reset behaviour and the gated bell path.
module tb_riscv_uart_wrapper;

  localparam int CPB = 16;  // 50 MHz / 3.125 Mbaud

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_rxd = 1'b1;
  logic       uart_rx_en = 1'b1;
  logic       uart_rx_break;
  logic       uart_rx_valid;
  logic [7:0] uart_rx_data;
  logic       input_gpio_pins = 1'b0;
  logic       output_gpio_pins;
  logic       write_done;

  int errors = 0;
  int checks = 0;

  int         cyc = 0;
  int         valid_cnt = 0;
  int         break_cnt = 0;
  logic [7:0] last_data = 8'h00;
  int         last_valid_cyc = 0;
  int         done_cyc = 0;
  bit         done_seen = 1'b0;

  riscv_uart_wrapper #(
    .CLK_HZ(50_000_000),
    .BIT_RATE(3_125_000),
    .IMEM_DEPTH(4),
    .END_MARKER(32'hFFFF_FFFF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .uart_rxd(uart_rxd),
    .uart_rx_en(uart_rx_en),
    .uart_rx_break(uart_rx_break),
    .uart_rx_valid(uart_rx_valid),
    .uart_rx_data(uart_rx_data),
    .input_gpio_pins(input_gpio_pins),
    .output_gpio_pins(output_gpio_pins),
    .write_done(write_done)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (uart_rx_valid) begin
      valid_cnt      <= valid_cnt + 1;
      last_data      <= uart_rx_data;
      last_valid_cyc <= cyc;
    end
    if (uart_rx_break) break_cnt <= break_cnt + 1;
    if (rst) done_seen <= 1'b0;
    else if (write_done && !done_seen) begin
      done_seen <= 1'b1;
      done_cyc  <= cyc;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    uart_rxd = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      wait_cycles(CPB);
    end
    uart_rxd = 1'b1;
    wait_cycles(3 * CPB);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(2);
  endtask

  task automatic test_reset();
    wait_cycles(200);
    checks++; if (uart_rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", uart_rx_valid); end
    checks++; if (uart_rx_break !== 1'b0) begin errors++; $display("FAIL reset_break got=%b want=0", uart_rx_break); end
    checks++; if (uart_rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h want=00", uart_rx_data); end
    checks++; if (write_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", write_done); end
    checks++; if (output_gpio_pins !== 1'b0) begin errors++; $display("FAIL reset_gpio got=%b want=0", output_gpio_pins); end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      input_gpio_pins = ~input_gpio_pins;
      wait_cycles(150);
      checks++;
      if (output_gpio_pins !== 1'b0) begin
        errors++; $display("FAIL gpio_unloaded_%0d got=%b want=0", i, output_gpio_pins);
      end
    end
    input_gpio_pins = 1'b0;
  endtask

  task automatic test_single_byte();
    int v0, b0;
    v0 = valid_cnt; b0 = break_cnt;
    send_byte(8'h13);
    checks++; if (valid_cnt !== v0 + 1) begin errors++; $display("FAIL single_valid_count got=%0d want=%0d", valid_cnt - v0, 1); end
    checks++; if (uart_rx_data !== 8'b0001_0011) begin errors++; $display("FAIL single_data got=%h want=13", uart_rx_data); end
    checks++; if (break_cnt !== b0) begin errors++; $display("FAIL single_break got=%0d want=0", break_cnt - b0); end
    apply_reset();
  endtask

  task automatic test_load_words();
    logic [7:0] bytes [8];
    bytes = '{8'h13, 8'h01, 8'h01, 8'hFE, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 8; i++) begin
      send_byte(bytes[i]);
      checks++;
      if (last_data !== bytes[i]) begin
        errors++; $display("FAIL load_byte_%0d got=%h want=%h", i, last_data, bytes[i]);
      end
    end
    checks++; if (dut.imem_q[0] !== 32'hFE01_0113) begin errors++; $display("FAIL imem0 got=%h want=fe010113", dut.imem_q[0]); end
    checks++; if (dut.imem_q[1] !== 32'h0000_0000) begin errors++; $display("FAIL imem1 got=%h want=00000000", dut.imem_q[1]); end
    checks++; if (write_done !== 1'b0) begin errors++; $display("FAIL load_done got=%b want=0", write_done); end
  endtask

  task automatic test_end_marker();
    for (int i = 0; i < 4; i++) send_byte(8'hFF);
    checks++; if (write_done !== 1'b1) begin errors++; $display("FAIL marker_done got=%b want=1", write_done); end
    checks++;
    if (!done_seen || done_cyc - last_valid_cyc > 1 || done_cyc < last_valid_cyc) begin
      errors++; $display("FAIL marker_latency got=%0d want<=1 cycles", done_cyc - last_valid_cyc);
    end
    checks++; if (dut.imem_q[2] === 32'hFFFF_FFFF) begin errors++; $display("FAIL marker_written got=%h want!=ffffffff", dut.imem_q[2]); end
    @(negedge clk);
    input_gpio_pins = 1'b1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    checks++; if (output_gpio_pins !== 1'b0) begin errors++; $display("FAIL bell_early got=%b want=0", output_gpio_pins); end
    @(posedge clk); @(negedge clk);
    checks++; if (output_gpio_pins !== 1'b1) begin errors++; $display("FAIL bell_on got=%b want=1", output_gpio_pins); end
    input_gpio_pins = 1'b0;
    wait_cycles(3);
    checks++; if (output_gpio_pins !== 1'b0) begin errors++; $display("FAIL bell_off got=%b want=0", output_gpio_pins); end
  endtask

  task automatic test_break();
    int v0, b0;
    v0 = valid_cnt; b0 = break_cnt;
    uart_rxd = 1'b0;
    wait_cycles(11 * CPB);
    uart_rxd = 1'b1;
    wait_cycles(2 * CPB);
    checks++; if (break_cnt !== b0 + 1) begin errors++; $display("FAIL break_count got=%0d want=1", break_cnt - b0); end
    checks++; if (valid_cnt !== v0) begin errors++; $display("FAIL break_valid got=%0d want=0", valid_cnt - v0); end
    checks++; if (uart_rx_data !== 8'hFF) begin errors++; $display("FAIL break_data got=%h want=ff", uart_rx_data); end
  endtask

  task automatic test_rx_enable();
    int v0;
    v0 = valid_cnt;
    uart_rx_en = 1'b0;
    send_byte(8'h55);
    uart_rx_en = 1'b1;
    checks++; if (valid_cnt !== v0) begin errors++; $display("FAIL en_low_valid got=%0d want=0", valid_cnt - v0); end
    uart_rxd = 1'b0;
    wait_cycles(4 * CPB);
    uart_rx_en = 1'b0;
    uart_rxd = 1'b1;
    wait_cycles(8 * CPB);
    uart_rx_en = 1'b1;
    wait_cycles(2 * CPB);
    checks++; if (valid_cnt !== v0) begin errors++; $display("FAIL en_abort_valid got=%0d want=0", valid_cnt - v0); end
    send_byte(8'h3C);
    checks++; if (uart_rx_data !== 8'h3C) begin errors++; $display("FAIL en_restore_data got=%h want=3c", uart_rx_data); end
  endtask

  task automatic test_reset_mid_word();
    int v0;
    input_gpio_pins = 1'b1;
    apply_reset();
    checks++; if (write_done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b want=0", write_done); end
    checks++; if (output_gpio_pins !== 1'b0) begin errors++; $display("FAIL rst_gpio got=%b want=0", output_gpio_pins); end
    send_byte(8'hAA);
    send_byte(8'hBB);
    v0 = valid_cnt;
    uart_rxd = 1'b0;
    wait_cycles(4 * CPB);
    rst = 1'b1;
    uart_rxd = 1'b1;
    wait_cycles(2);
    checks++; if (uart_rx_data !== 8'h00) begin errors++; $display("FAIL rst_mid_data got=%h want=00", uart_rx_data); end
    rst = 1'b0;
    wait_cycles(12 * CPB);
    checks++; if (valid_cnt !== v0) begin errors++; $display("FAIL rst_mid_valid got=%0d want=0", valid_cnt - v0); end
    checks++; if (dut.imem_q[0] !== 32'hFE01_0113) begin errors++; $display("FAIL rst_imem_kept got=%h want=fe010113", dut.imem_q[0]); end
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    checks++; if (dut.imem_q[0] !== 32'h4433_2211) begin errors++; $display("FAIL rst_reload got=%h want=44332211", dut.imem_q[0]); end
    checks++; if (dut.imem_q[1] !== 32'h0000_0000) begin errors++; $display("FAIL rst_imem1 got=%h want=00000000", dut.imem_q[1]); end
    checks++; if (write_done !== 1'b0) begin errors++; $display("FAIL rst_reload_done got=%b want=0", write_done); end
    input_gpio_pins = 1'b0;
  endtask

  task automatic test_depth_full();
    logic [7:0] bytes [16];
    bytes = '{8'hD4, 8'hC3, 8'hB2, 8'hA1, 8'h13, 8'h00, 8'h00, 8'h00,
              8'h78, 8'h56, 8'h34, 8'h12, 8'h55, 8'h66, 8'h77, 8'h88};
    for (int i = 0; i < 8; i++) send_byte(bytes[i]);
    checks++; if (write_done !== 1'b0) begin errors++; $display("FAIL full_early_done got=%b want=0", write_done); end
    for (int i = 8; i < 12; i++) send_byte(bytes[i]);
    checks++; if (write_done !== 1'b1) begin errors++; $display("FAIL full_done got=%b want=1", write_done); end
    checks++; if (dut.imem_q[1] !== 32'hA1B2_C3D4) begin errors++; $display("FAIL full_imem1 got=%h want=a1b2c3d4", dut.imem_q[1]); end
    checks++; if (dut.imem_q[3] !== 32'h1234_5678) begin errors++; $display("FAIL full_imem3 got=%h want=12345678", dut.imem_q[3]); end
    for (int i = 12; i < 16; i++) send_byte(bytes[i]);
    checks++; if (uart_rx_data !== 8'h88) begin errors++; $display("FAIL full_rx_data got=%h want=88", uart_rx_data); end
    checks++; if (dut.imem_q[0] !== 32'h4433_2211) begin errors++; $display("FAIL full_discard got=%h want=44332211", dut.imem_q[0]); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_load_words();
    test_end_marker();
    test_break();
    test_rx_enable();
    test_reset_mid_word();
    test_depth_full();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/riscv_uart_wrapper.md
Name: riscv_uart_wrapper

Overview:
Top-level wrapper of the touch-bell RISC-V SoC. It combines an 8N1 UART receiver, a program loader and a single-bit GPIO bell path. The loader packs received bytes into 32-bit little-endian words and writes them into an internal instruction memory until an end marker arrives. After loading completes, the bell output follows the touch input.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz
BIT_RATE, 9600, UART baud rate
CLKS_PER_BIT, CLK_HZ/BIT_RATE (5208), clock cycles per UART bit (integer division)
IMEM_DEPTH, 32, instruction memory depth in 32-bit words
END_MARKER, 32'hFFFFFFFF, word that terminates loading

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  reset, asynchronous, active-high
uart_rxd  input  1  UART serial line, idle high
uart_rx_en  input  1  receive enable; must be driven, 0 holds receiver idle
uart_rx_break  output  1  one-cycle pulse when a BREAK frame is received
uart_rx_valid  output  1  one-cycle pulse when a valid byte is received
uart_rx_data  output  8  last received byte, held until the next valid byte
input_gpio_pins  input  1  touch sensor input (asynchronous to clk)
output_gpio_pins  output  1  bell drive output
write_done  output  1  program load complete; sticky until rst

Behaviour:
- Reset (rst=1, async): all outputs are 0, the receiver returns to IDLE, and the loader byte/word counters clear. IMEM contents are not cleared.
- uart_rxd passes through a 2-flop synchronizer before use.
- Receiver FSM states are IDLE, START, DATA, STOP.
  - IDLE: if uart_rx_en=1 and the synced line is 0, go to START and clear the bit counter.
  - START: sample at CLKS_PER_BIT/2. If the line is still 0, go to DATA; otherwise treat it as a glitch and return to IDLE.
  - DATA: sample 8 bits, each CLKS_PER_BIT after the previous sample, LSB first.
  - STOP: sample once more after CLKS_PER_BIT.
    - Stop bit = 1: load uart_rx_data and pulse uart_rx_valid for 1 cycle.
    - Stop bit = 0 and data = 0x00: pulse uart_rx_break for 1 cycle; no valid pulse; uart_rx_data is unchanged. Then wait for the line to return to 1 before re-entering IDLE.
    - Stop bit = 0 and data != 0x00: framing error; drop the byte with no pulses.
- uart_rx_en=0 mid-frame: abort the frame and return to IDLE with no output pulse.
- Latency: uart_rx_valid rises about 9.5 bit times (plus 2-3 cycles of synchronizer delay) after the start-bit falling edge.
- Loader (active while write_done=0):
  - On each uart_rx_valid, place the byte into the word buffer at byte lane byte_cnt (lane 0 = bits[7:0]), then increment byte_cnt mod 4.
  - On the 4th byte, the assembled word is complete:
    - If it equals END_MARKER: do not write it; set write_done.
    - Otherwise: write imem[word_addr] = word and increment word_addr.
  - When word_addr reaches IMEM_DEPTH, set write_done; any further words are discarded.
  - Break pulses do not affect the loader.
- After write_done=1, bytes are still reported on the uart_rx_* outputs but are ignored by the loader. write_done clears only on rst.
- GPIO:
  - input_gpio_pins passes through a 2-flop synchronizer.
  - While write_done=0: output_gpio_pins = 0.
  - While write_done=1: output_gpio_pins is registered from the synced input (bell on when touched, off when not). Latency is 3 cycles from an input edge.
- Instruction memory: IMEM_DEPTH x 32 synchronous-write register array. A read port is available for the core at an internal word address. The core itself is outside this block's scope.
- Simultaneous events: rst dominates everything. A valid byte and a counter wrap in the same cycle is handled as one atomic update.

Test Plan:
- Hold rst=1 for 4 us with uart_rxd=1 -> all outputs 0. Release rst with input_gpio_pins toggling every 3 us -> output_gpio_pins stays 0 (no program loaded).
- Send byte 0x13 at 9600 baud (104167 ns per bit) -> one uart_rx_valid pulse, uart_rx_data=8'b00010011, uart_rx_break=0.
- Send 13,01,01,FE then 00,00,00,00 -> uart_rx_data matches each byte in order. imem[0]=32'hFE010113, imem[1]=0, write_done=0.
- Send FF,FF,FF,FF -> write_done rises within 1 cycle of the 4th valid pulse and is not written to IMEM. Afterwards, input_gpio_pins 0->1 gives output_gpio_pins=1 after 3 cycles; 1->0 gives output_gpio_pins=0.
- Drive uart_rxd low for 11 bit times -> uart_rx_break pulses once, no uart_rx_valid, uart_rx_data unchanged.
- Assert rst mid-frame and midway through a word, then resend a full word -> loader restarts at byte lane 0 and write_done=0.
